// File: rtl/pipe_scroller.sv
`timescale 1ns/1ps
// pipe_scroller: Flappy Bird pipe field. A COLS x ROWS obstacle bitmap scrolls left
// one column per tick, gapped pipes spawn at the right edge, and passes are scored.
module pipe_scroller #(
  parameter int ROWS         = 8,
  parameter int COLS         = 16,
  parameter int GAP_H        = 3,
  parameter int PIPE_SPACING = 6,
  parameter int BIRD_COL     = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    over,
  input  logic                    restart,
  input  logic [2:0]              gap_sel,
  input  logic [$clog2(COLS)-1:0] col_sel,
  output logic [ROWS-1:0]         col_data,
  output logic [ROWS-1:0]         bird_col_data,
  output logic [7:0]              score,
  output logic                    pipe_pass
);

  localparam int CSW = $clog2(COLS);
  localparam int CW  = $clog2(PIPE_SPACING);
  localparam int BW  = ($clog2(ROWS) + 2 > 4) ? $clog2(ROWS) + 2 : 4;
  localparam logic [ROWS-1:0] GAP_ONES = ROWS'((1 << GAP_H) - 1);
  localparam logic [BW-1:0]   MAX_BASE = BW'(ROWS - GAP_H);

  logic [ROWS-1:0] cols [COLS];
  logic [CW-1:0]   spawn_cnt;
  logic [BW-1:0]   base;
  logic [ROWS-1:0] spawn_pat;

  // Gap base is clamped so the whole gap stays inside the column.
  always_comb begin
    base = BW'(gap_sel);
    if (BW'(gap_sel) + BW'(GAP_H) > BW'(ROWS))
      base = MAX_BASE;
    spawn_pat = ~(GAP_ONES << base);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < COLS; i++)
        cols[i] <= '0;
      spawn_cnt <= '0;
      score     <= '0;
      pipe_pass <= 1'b0;
    end else if (restart) begin
      for (int i = 0; i < COLS; i++)
        cols[i] <= '0;
      spawn_cnt <= '0;
      score     <= '0;
      pipe_pass <= 1'b0;
    end else begin
      pipe_pass <= 1'b0;
      if (!over && tick) begin
        for (int i = 0; i < COLS - 1; i++)
          cols[i] <= cols[i+1];
        cols[COLS-1] <= (spawn_cnt == '0) ? spawn_pat : '0;
        spawn_cnt    <= (spawn_cnt == '0) ? CW'(PIPE_SPACING - 1) : spawn_cnt - CW'(1);
        // A pass is the pre-shift bird column holding pipe pixels.
        if (cols[BIRD_COL] != '0 && score != 8'hFF) begin
          score     <= score + 8'd1;
          pipe_pass <= 1'b1;
        end
      end
    end
  end

  assign bird_col_data = cols[BIRD_COL];

  generate
    if ((1 << CSW) > COLS) begin : g_ranged
      assign col_data = (col_sel < CSW'(COLS)) ? cols[col_sel] : '0;
    end else begin : g_full
      assign col_data = cols[col_sel];
    end
  endgenerate

endmodule
